// File: rtl/ram_rd_streamer.sv
// Burst read master for a registered-output RAM read port, returning words as a valid/ready
// stream through a 2-entry skid buffer. Optional bounds check: RAM_RD_STREAMER_BOUND_CHECK_EN.
module ram_rd_streamer #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
`ifdef RAM_RD_STREAMER_BOUND_CHECK_EN
  ,
  output logic                  cmd_err
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [LEN_WIDTH:0]    RemOne  = (LEN_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH:0]    rem_q, rem_d;
  logic                  inflight_q, inflight_last_q;
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic                  fifo_last_q [2];
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            occ_q, occ_d;

  logic       push, pop, issue_ok, bound_err;
  logic [2:0] level, limit;

`ifdef RAM_RD_STREAMER_BOUND_CHECK_EN
  localparam int unsigned SumWidth = (ADDR_WIDTH > LEN_WIDTH ? ADDR_WIDTH : LEN_WIDTH) + 1;
  logic [SumWidth-1:0] span;
  logic                cmd_err_q, cmd_err_d;

  // Last word address must not carry past the top of the RAM.
  assign span      = SumWidth'(cmd_addr) + SumWidth'(cmd_len);
  assign bound_err = (span >> ADDR_WIDTH) != '0;
  assign cmd_err   = cmd_err_q;
`else
  assign bound_err = 1'b0;
`endif

  assign out_valid   = occ_q != 2'd0;
  assign out_data    = fifo_data_q[rd_ptr_q];
  assign out_last    = out_valid & fifo_last_q[rd_ptr_q];
  assign mem_rd_addr = addr_q;
  assign push        = inflight_q;
  assign pop         = out_valid & out_ready;

  // Words owned after this edge (buffered + in flight - popped) must leave room for one more.
  assign level    = {1'b0, occ_q} + {2'b00, inflight_q};
  assign limit    = 3'd1 + {2'b00, pop};
  assign issue_ok = level <= limit;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    mem_rd_en = 1'b0;
`ifdef RAM_RD_STREAMER_BOUND_CHECK_EN
    cmd_err_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (bound_err) begin
`ifdef RAM_RD_STREAMER_BOUND_CHECK_EN
            cmd_err_d = 1'b1;
`endif
          end else begin
            addr_d  = cmd_addr;
            rem_d   = (LEN_WIDTH + 1)'(cmd_len) + RemOne;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        busy = 1'b1;
        if (rem_q != '0 && issue_ok) begin
          mem_rd_en = 1'b1;
          addr_d    = addr_q + AddrOne;
          rem_d     = rem_q - RemOne;
          if (rem_q == RemOne) state_d = StDrain;
        end
      end
      StDrain: begin
        busy = 1'b1;
        if (pop && out_last && occ_q == 2'd1 && !inflight_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (!push && pop) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      occ_q           <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
`ifdef RAM_RD_STREAMER_BOUND_CHECK_EN
      cmd_err_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= mem_rd_en;
      inflight_last_q <= mem_rd_en && (rem_q == RemOne);
      occ_q           <= occ_d;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_rd_data;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
`ifdef RAM_RD_STREAMER_BOUND_CHECK_EN
      cmd_err_q       <= cmd_err_d;
`endif
    end
  end

endmodule

// File: doc/ram_rd_streamer.md
Name: ram_rd_streamer

Overview:
- Read-side master for a 1-write/1-read RAM with a registered read port (1-cycle read latency). It drives that port on the same clock.
- Accepts a burst command (start address, word count) and issues sequential RAM reads.
- Returns the read data as a valid/ready stream, with last-word marking and full backpressure.
- Sits between on-chip buffer RAMs and stream consumers (DMA egress, packet readers).

Parameters:
- ADDR_WIDTH, 5, RAM address width; matches the RAM's read address width.
- DATA_WIDTH, 32, RAM word width and stream data width.
- LEN_WIDTH, 6, width of the burst length field; a burst is cmd_len+1 words, so 1..2^LEN_WIDTH words.

Ports:
- clk  in  1  single clock; also drives the RAM read-port clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  ADDR_WIDTH  first word address.
- cmd_len  in  LEN_WIDTH  word count minus 1.
- mem_rd_en  out  1  RAM read enable.
- mem_rd_addr  out  ADDR_WIDTH  RAM read address.
- mem_rd_data  in  DATA_WIDTH  RAM read data; valid the cycle after mem_rd_en.
- out_valid  out  1  stream data valid.
- out_ready  in  1  consumer ready.
- out_data  out  DATA_WIDTH  stream word.
- out_last  out  1  marks the final word of the burst.
- busy  out  1  high in RUN and DRAIN.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - cmd_ready=1, busy=0, mem_rd_en=0, mem_rd_addr=0.
  - out_valid=0, out_last=0, out_data=0.
  - Buffer, counters and in-flight flag are cleared.
  - An in-flight read return is discarded. Reset mid-burst needs no drain.
- State IDLE:
  - cmd_ready=1.
  - cmd handshake (cmd_valid & cmd_ready): latch addr_q=cmd_addr and remaining=cmd_len+1 (LEN_WIDTH+1 bits), then go to RUN.
- State RUN:
  - mem_rd_en=1 when remaining!=0 and (occ + inflight - pop) <= 1, where:
    - occ = skid buffer occupancy, 0..2.
    - inflight = 1 if mem_rd_en was high last cycle.
    - pop = out_valid & out_ready.
  - mem_rd_en is combinational from out_ready; no other input paths exist.
  - mem_rd_addr = addr_q.
  - On each issue: addr_q increments modulo 2^ADDR_WIDTH (wraps 2^ADDR_WIDTH-1 -> 0) and remaining decrements.
  - remaining reaching 0 -> DRAIN.
- State DRAIN:
  - No reads are issued.
  - When the buffer is empty, inflight=0, and the last word is popped -> IDLE. cmd_ready=1 the next cycle.
- Skid buffer:
  - 2-entry FIFO.
  - Push mem_rd_data in the cycle after an issued read; push and pop may occur in the same cycle.
  - Never overflows, by the issue rule.
  - out_data/out_valid/out_last come from the head entry, registered.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
- out_last: set on the word of issue index cmd_len; stored per entry.
- Latency:
  - Command handshake at edge E0.
  - First mem_rd_en in the cycle after E0.
  - First out_valid two cycles later (third cycle after E0).
- Throughput: 1 word/clk with out_ready held high. A stall of any length causes no loss or duplication.
- Single-word burst (cmd_len=0): one read, out_last=1 on that word.

Optional Feature:
- Macro: RAM_RD_STREAMER_BOUND_CHECK_EN.
- Defined:
  - Adds output port cmd_err (1 bit, reset 0).
  - If cmd_addr + cmd_len > 2^ADDR_WIDTH-1 at handshake, the command is consumed with no reads issued.
  - cmd_err pulses 1 for exactly one cycle, the cycle after the handshake.
  - State remains IDLE.
- Undefined: no cmd_err port; addresses wrap modulo 2^ADDR_WIDTH as above.

Test Plan:
- RAM words = index*0x11111111. Command addr=4, len=3, out_ready=1 -> out_data 0x44444444, 0x55555555, 0x66666666, 0x77777777 on 4 consecutive cycles; out_last only on 0x77777777; first out_valid 3 cycles after the handshake.
- addr=0, len=7, out_ready toggled 1,0,0,1,... randomly -> exactly 8 words in order, with no drop or duplicate; out_data is stable while stalled; buffer occ never exceeds 2; mem_rd_en pauses while occ+inflight would exceed 2.
- ADDR_WIDTH=5, addr=30, len=3 with the macro undefined -> mem_rd_addr sequence 30, 31, 0, 1. With the macro defined -> no mem_rd_en, cmd_err=1 for one cycle, cmd_ready=1 again.
- cmd_len=0 at addr 9 -> single word 0x99999999 with out_last=1; busy=0 and cmd_ready=1 the cycle after the pop. Back-to-back commands are accepted.
- rst_n asserted mid-burst (after 2 of 8 words) with a read in flight -> outputs immediately at reset values. After release, a new command addr=2, len=1 returns exactly 0x22222222 and 0x33333333.
- cmd_valid held high during RUN -> cmd_ready=0, second command is not latched until IDLE; then accepted and executed.
